// File: rtl/riscv_trace_buffer_if.sv
// Retirement tap and readout handshake for the trace buffer.
// The buffer takes the slave side; the core tap / consumer takes the master side.
interface riscv_trace_buffer_if #(
   parameter int XLEN = 32
);
   logic                ret_valid;
   logic [XLEN-1:0]     pc;
   logic [XLEN-1:0]     instruction;
   logic                rd_valid;
   logic                rd_ready;
   logic [2*XLEN-1:0]   rd_data;

   modport master (
      output ret_valid, pc, instruction, rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  ret_valid, pc, instruction, rd_ready,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/riscv_trace_buffer.sv
// Circular retirement trace capture: records {pc, instruction} until POST_TRIG
// entries past a PC-match trigger, then replays the window oldest-first.
//
// state | meaning
// IDLE  | no capture; waiting for arm
// ARMED | recording every retirement, watching for pc == trig_pc
// POST  | trigger seen; recording post_cnt more retirements
// DONE  | capture frozen; draining entries over rd_valid/rd_ready
module riscv_trace_buffer #(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   riscv_trace_buffer_if.slave      trc,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [XLEN-1:0]          trig_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy,
   output logic                     done
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_nxt;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_nxt;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_nxt;
   logic [CW-1:0]      count_q, count_nxt;
   logic [PW-1:0]      post_cnt_q, post_cnt_nxt;
   logic               wr_en;
   logic               rd_valid_int;
   logic [2*XLEN-1:0]  mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         post_cnt_q <= '0;
      end else begin
         state_q    <= state_nxt;
         wr_ptr_q   <= wr_ptr_nxt;
         rd_ptr_q   <= rd_ptr_nxt;
         count_q    <= count_nxt;
         post_cnt_q <= post_cnt_nxt;
      end
   end

   // Storage carries no reset; count bounds what is ever read out.
   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_q] <= {trc.pc, trc.instruction};
   end

   always_comb begin
      state_nxt    = state_q;
      wr_ptr_nxt   = wr_ptr_q;
      rd_ptr_nxt   = rd_ptr_q;
      count_nxt    = count_q;
      post_cnt_nxt = post_cnt_q;
      wr_en        = 1'b0;

      if (abort) begin
         state_nxt    = IDLE;
         wr_ptr_nxt   = '0;
         rd_ptr_nxt   = '0;
         count_nxt    = '0;
         post_cnt_nxt = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (arm) begin
                  state_nxt    = ARMED;
                  wr_ptr_nxt   = '0;
                  rd_ptr_nxt   = '0;
                  count_nxt    = '0;
                  post_cnt_nxt = '0;
               end
            end

            ARMED: begin
               if (trc.ret_valid) begin
                  wr_en      = 1'b1;
                  wr_ptr_nxt = wr_ptr_q + 1'b1;
                  if (count_q != CW'(DEPTH))
                     count_nxt = count_q + 1'b1;
                  if (trc.pc == trig_pc) begin
                     if (POST_TRIG == 0) begin
                        state_nxt = DONE;
                     end else begin
                        state_nxt    = POST;
                        post_cnt_nxt = PW'(POST_TRIG);
                     end
                  end
               end
            end

            POST: begin
               if (trc.ret_valid) begin
                  wr_en        = 1'b1;
                  wr_ptr_nxt   = wr_ptr_q + 1'b1;
                  post_cnt_nxt = post_cnt_q - 1'b1;
                  if (count_q != CW'(DEPTH))
                     count_nxt = count_q + 1'b1;
                  if (post_cnt_q == PW'(1))
                     state_nxt = DONE;
               end
            end

            DONE: begin
               if (rd_valid_int && trc.rd_ready) begin
                  rd_ptr_nxt = rd_ptr_q + 1'b1;
                  count_nxt  = count_q - 1'b1;
                  if (count_q == CW'(1))
                     state_nxt = IDLE;
               end
            end

            default: state_nxt = IDLE;
         endcase

         // Point the reader at the oldest entry as the capture freezes.
         if (state_q != DONE && state_nxt == DONE)
            rd_ptr_nxt = wr_ptr_nxt - count_nxt[PW-1:0];
      end
   end

   assign rd_valid_int = (state_q == DONE) && (count_q != '0);
   assign trc.rd_valid = rd_valid_int;
   assign trc.rd_data  = rd_valid_int ? mem[rd_ptr_q] : '0;
   assign count        = count_q;
   assign busy         = (state_q == ARMED) || (state_q == POST);
   assign done         = (state_q == DONE);

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Scoreboard bench for riscv_trace_buffer: a 16/8 instance and a 4/0 instance
// share stimulus; a queue model of the capture window supplies expected readout.
module tb_riscv_trace_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ret_valid = 1'b0;
   logic        rd_ready = 1'b0;
   logic        abort = 1'b0;
   logic        arm_a = 1'b0;
   logic        arm_b = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] instruction = '0;
   logic [31:0] trig_pc = '0;
   logic        sel = 1'b0;

   logic [4:0]  count_a;
   logic [2:0]  count_b;
   logic        busy_a, busy_b, done_a, done_b;

   always #5 clk = ~clk;

   riscv_trace_buffer_if #(.XLEN(32)) trc_a ();
   riscv_trace_buffer_if #(.XLEN(32)) trc_b ();

   assign trc_a.ret_valid   = ret_valid;
   assign trc_a.pc          = pc;
   assign trc_a.instruction = instruction;
   assign trc_a.rd_ready    = rd_ready;
   assign trc_b.ret_valid   = ret_valid;
   assign trc_b.pc          = pc;
   assign trc_b.instruction = instruction;
   assign trc_b.rd_ready    = rd_ready;

   riscv_trace_buffer #(.XLEN(32), .DEPTH(16), .POST_TRIG(8)) u_dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .trc     (trc_a),
      .arm     (arm_a),
      .abort   (abort),
      .trig_pc (trig_pc),
      .count   (count_a),
      .busy    (busy_a),
      .done    (done_a)
   );

   riscv_trace_buffer #(.XLEN(32), .DEPTH(4), .POST_TRIG(0)) u_dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .trc     (trc_b),
      .arm     (arm_b),
      .abort   (abort),
      .trig_pc (trig_pc),
      .count   (count_b),
      .busy    (busy_b),
      .done    (done_b)
   );

   logic [4:0]  obs_count;
   logic        obs_busy, obs_done, obs_rd_valid;
   logic [63:0] obs_rd_data;

   assign obs_count    = sel ? {2'b00, count_b} : count_a;
   assign obs_busy     = sel ? busy_b : busy_a;
   assign obs_done     = sel ? done_b : done_a;
   assign obs_rd_valid = sel ? trc_b.rd_valid : trc_a.rd_valid;
   assign obs_rd_data  = sel ? trc_b.rd_data : trc_a.rd_data;

   int          n_chk = 0;
   int          n_pass = 0;
   logic [63:0] sb_q[$];
   int          m_trig, m_done, m_post;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
   endtask

   function automatic logic [31:0] ins_of(input logic [31:0] p);
      return (p * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic arm_dut(input logic [31:0] trig);
      trig_pc = trig;
      sb_q.delete();
      m_trig = 0;
      m_done = 0;
      m_post = 0;
      if (sel) arm_b = 1'b1; else arm_a = 1'b1;
      step();
      arm_a = 1'b0;
      arm_b = 1'b0;
      check_val("arm_busy", 64'(obs_busy), 64'd1);
      check_val("arm_count", 64'(obs_count), 64'd0);
   endtask

   task automatic feed(input logic [31:0] start, input int n);
      int depth, post;
      depth = sel ? 4 : 16;
      post  = sel ? 0 : 8;
      for (int i = 0; i < n; i++) begin
         logic [31:0] p;
         p = start + 32'(4 * i);
         ret_valid   = 1'b1;
         pc          = p;
         instruction = ins_of(p);
         if (m_done == 0) begin
            sb_q.push_back({p, ins_of(p)});
            if (sb_q.size() > depth) void'(sb_q.pop_front());
            if (m_trig != 0) begin
               m_post--;
               if (m_post == 0) m_done = 1;
            end else if (p == trig_pc) begin
               m_trig = 1;
               m_post = post;
               if (post == 0) m_done = 1;
            end
         end
         step();
         check_val("cap_count", 64'(obs_count), 64'(sb_q.size()));
         check_val("cap_done", 64'(obs_done), 64'(m_done));
      end
      ret_valid = 1'b0;
   endtask

   // mode 0: always ready; mode 1: three stall cycles, then ready every other cycle
   task automatic drain(input int mode);
      int cyc;
      cyc = 0;
      while (sb_q.size() > 0 && cyc < 200) begin
         logic rdy;
         if (mode == 1) rdy = (cyc < 3) ? 1'b0 : ((cyc % 2) == 1);
         else           rdy = 1'b1;
         rd_ready = rdy;
         check_val("rd_valid", 64'(obs_rd_valid), 64'd1);
         check_val("rd_data", obs_rd_data, sb_q[0]);
         if (rdy) void'(sb_q.pop_front());
         step();
         cyc++;
      end
      rd_ready = 1'b0;
      check_val("drain_left", 64'(sb_q.size()), 64'd0);
      check_val("drain_done", 64'(obs_done), 64'd0);
      check_val("drain_rd_valid", 64'(obs_rd_valid), 64'd0);
      check_val("drain_busy", 64'(obs_busy), 64'd0);
      check_val("drain_count", 64'(obs_count), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      #12;
      check_val("rst_rd_valid", 64'(obs_rd_valid), 64'd0);
      check_val("rst_rd_data", obs_rd_data, 64'd0);
      check_val("rst_busy", 64'(obs_busy), 64'd0);
      check_val("rst_done", 64'(obs_done), 64'd0);
      check_val("rst_count_b", 64'(count_b), 64'd0);
      rst_n = 1'b1;
      step();

      // asynchronous reset in the middle of a capture
      sel = 1'b0;
      arm_dut(32'h0000_FFF0);
      feed(32'h100, 5);
      check_val("mid_busy", 64'(obs_busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_count", 64'(obs_count), 64'd0);
      check_val("arst_busy", 64'(obs_busy), 64'd0);
      check_val("arst_done", 64'(obs_done), 64'd0);
      check_val("arst_rd_valid", 64'(obs_rd_valid), 64'd0);
      rst_n = 1'b1;
      step();
      ret_valid = 1'b1;
      trig_pc   = 32'h200;
      for (int i = 0; i < 3; i++) begin
         pc = 32'h200 + 32'(4 * i);
         instruction = ins_of(pc);
         step();
         check_val("idle_count", 64'(obs_count), 64'd0);
         check_val("idle_busy", 64'(obs_busy), 64'd0);
      end
      ret_valid = 1'b0;

      // basic trigger: 0x08 trigger, 8 post entries, 11 held
      arm_dut(32'h08);
      feed(32'h00, 11);
      check_val("basic_count", 64'(obs_count), 64'd11);
      drain(0);

      // wrap-around: oldest-first after overwrite, late retirements ignored
      arm_dut(32'h30);
      feed(32'h00, 24);
      check_val("wrap_count", 64'(obs_count), 64'd16);
      check_val("wrap_first", 64'(sb_q[0][63:32]), 64'h14);
      drain(0);

      // abort during POST with 4 entries still to go
      arm_dut(32'h08);
      feed(32'h00, 7);
      check_val("pre_abort_busy", 64'(obs_busy), 64'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      check_val("abort_busy", 64'(obs_busy), 64'd0);
      check_val("abort_count", 64'(obs_count), 64'd0);
      check_val("abort_done", 64'(obs_done), 64'd0);
      arm_dut(32'h208);
      feed(32'h200, 11);
      drain(1);

      // POST_TRIG=0 instance, DEPTH=4
      sel = 1'b1;
      arm_dut(32'h40);
      pc = 32'h40;
      instruction = ins_of(pc);
      ret_valid = 1'b0;
      step();
      step();
      check_val("notrig_done", 64'(obs_done), 64'd0);
      check_val("notrig_busy", 64'(obs_busy), 64'd1);
      feed(32'h30, 5);
      check_val("pt0_done", 64'(obs_done), 64'd1);
      check_val("pt0_count", 64'(obs_count), 64'd4);
      arm_b = 1'b1;
      step();
      arm_b = 1'b0;
      check_val("arm_in_done", 64'(obs_done), 64'd1);
      check_val("arm_in_done_count", 64'(obs_count), 64'd4);
      drain(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/riscv_trace_buffer.md
Name:
riscv_trace_buffer

Overview:
- Parametrised on-chip retirement trace capture for the `riscv` core.
- Successor to bench-only `pc`/`instruction` waveform dumping: records {pc, instruction} pairs into a circular buffer, stops a programmable number of entries after a PC-match trigger, then replays the captured window oldest-first over a valid/ready port.
- Sits beside the core and taps its `pc`/`instruction` outputs plus a retire strobe.

Parameters:
- XLEN, 32, width of pc and instruction.
- DEPTH, 16, buffer entries; power of two, >= 2.
- POST_TRIG, 8, entries captured after the trigger entry; 0 <= POST_TRIG <= DEPTH-1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- ret_valid  input  1  retire strobe; pc/instruction valid this cycle
- pc  input  XLEN  retiring PC
- instruction  input  XLEN  retiring instruction
- arm  input  1  start a capture (honoured in IDLE only)
- abort  input  1  return to IDLE from any state
- trig_pc  input  XLEN  trigger PC
- rd_valid  output  1  readout entry available
- rd_ready  input  1  consumer accepts entry
- rd_data  output  2*XLEN  {pc, instruction} of current entry
- count  output  $clog2(DEPTH)+1  valid entries held
- busy  output  1  state is ARMED or POST
- done  output  1  state is DONE

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; write pointer, read pointer, count and post counter = 0.
  - Outputs: rd_valid=0, rd_data=0, busy=0, done=0.
- State IDLE:
  - arm=1 -> ARMED next cycle; clears count and pointers.
  - ret_valid ignored.
- State ARMED:
  - Each ret_valid cycle writes {pc, instruction} at wr_ptr; wr_ptr increments mod DEPTH (wraps, overwrites oldest).
  - count increments, saturating at DEPTH.
  - Trigger = ret_valid && pc==trig_pc. The trigger entry is written.
  - On trigger: POST_TRIG>0 -> POST with post_cnt=POST_TRIG; POST_TRIG==0 -> DONE.
  - pc==trig_pc with ret_valid=0 is not a trigger.
- State POST:
  - Each ret_valid writes as in ARMED and decrements post_cnt.
  - The write that brings post_cnt to 0 -> DONE next cycle.
  - Further PC matches are ignored.
- State DONE:
  - Capture frozen; ret_valid and arm ignored.
  - rd_ptr starts at (wr_ptr - count) mod DEPTH, i.e. the oldest entry.
  - rd_valid = (count != 0); rd_data = mem[rd_ptr], combinational from the registered array.
  - Transfer when rd_valid && rd_ready: rd_ptr++ mod DEPTH, count--.
  - rd_valid && !rd_ready -> rd_data and rd_valid held stable.
  - Accepted transfer with count==1 -> IDLE next cycle; done and rd_valid deassert.
- abort:
  - Highest priority; any state -> IDLE next cycle.
  - Clears count, pointers and post_cnt.
  - Any in-flight readout is discarded.
- Latency:
  - Write visible one cycle after the ret_valid edge.
  - done rises the cycle after the final POST write.
- busy/done/rd_valid are decoded from the registered state and count, so they are glitch-free.
- Width rules: count holds 0..DEPTH inclusive; pointers are $clog2(DEPTH) bits with natural wrap.

Test Plan:
- Reset: assert rst_n=0 mid-capture (ARMED, count=5) -> asynchronously rd_valid=0, busy=0, done=0, count=0; after release state is IDLE and ret_valid is ignored.
- Basic trigger (DEPTH=16, POST_TRIG=8):
  - Stimulus: arm, trig_pc=0x08, retire pc 0x00,0x04,...,0x28.
  - Required: trigger at 0x08; done=1 the cycle after pc 0x28; count=11.
  - Readout: pcs 0x00..0x28 in order.
- Wrap-around:
  - Stimulus: arm, trig_pc=0x30, retire 24 pcs 0x00..0x5C step 4.
  - Required: done after pc 0x50; pcs 0x54..0x5C ignored; count=16.
  - Readout: 0x14..0x50 oldest-first, with each instruction matching its pc.
- Backpressure: in DONE, hold rd_ready=0 for 3 cycles -> rd_valid=1 and rd_data unchanged; alternate rd_ready 1/0 -> one entry per accepted cycle; after the last entry, done=0 and state is IDLE.
- Abort: abort in POST with post_cnt=4 -> next cycle busy=0, count=0, done=0; a subsequent arm starts a fresh capture with no stale entries.
- Corner cases:
  - pc==trig_pc with ret_valid=0 -> no trigger.
  - POST_TRIG=0 -> done the cycle after the trigger write.
  - arm asserted in DONE -> ignored; count unchanged.
